// File: rtl/tiny_nn_result_tx.sv
// Result transmit path: canonicalises fp_t results, queues them in a small FIFO
// and serialises each as a high byte then a low byte on the output bus.
module tiny_nn_result_tx #(
   parameter int FifoDepth  = 4,
   parameter int CountWidth = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  res_valid_i,
   output logic                  res_ready_o,
   input  logic [15:0]           res_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [7:0]            out_data_o,
   output logic                  out_hi_o,
   output logic                  empty_o,
   output logic [CountWidth-1:0] nan_count_o
);

   localparam int AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(FifoDepth);

   typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_e;

   state_e                       state_q, state_d;
   logic [FifoDepth-1:0][15:0]   mem_q, mem_d;
   logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]                  cnt_q, cnt_d;
   logic [15:0]                  res_q, res_d;
   logic                         out_valid_q, out_valid_d;
   logic                         out_hi_q, out_hi_d;
   logic [7:0]                   out_data_q, out_data_d;
   logic [CountWidth-1:0]        nan_cnt_q, nan_cnt_d;

   logic        fifo_full, fifo_empty, push, pop, is_nan;
   logic [15:0] canon, head;

   assign fifo_full  = (cnt_q == CNT_FULL);
   assign fifo_empty = (cnt_q == '0);
   assign head       = mem_q[rd_ptr_q];

   // Zero exponent with a set sign (including -0) is treated as NaN too.
   assign is_nan = ((res_i[14:7] == 8'h00) && ((res_i[6:0] != 7'd0) || res_i[15])) ||
                   ((res_i[14:7] == 8'hFF) && (res_i[6:0] != 7'd0));
   assign canon  = is_nan ? 16'hFFFF : res_i;

   assign res_ready_o = !fifo_full && !flush_i && !rst_i;
   assign push        = res_valid_i && res_ready_o;

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_hi_o    = out_hi_q;
   assign nan_count_o = nan_cnt_q;
   assign empty_o     = fifo_empty && (state_q == IDLE);

   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_hi_d    = out_hi_q;
      pop         = 1'b0;

      // Queued entries are never started on a flush edge; they are being discarded.
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !flush_i) pop = 1'b1;
         end
         SEND_HI: begin
            if (out_ready_i) begin
               state_d    = SEND_LO;
               out_data_d = res_q[7:0];
               out_hi_d   = 1'b0;
            end
         end
         SEND_LO: begin
            if (out_ready_i) begin
               if (!fifo_empty && !flush_i) begin
                  pop = 1'b1;
               end else begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         state_d     = SEND_HI;
         res_d       = head;
         out_valid_d = 1'b1;
         out_data_d  = head[15:8];
         out_hi_d    = 1'b1;
      end
   end

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      nan_cnt_d = nan_cnt_q;

      if (push && is_nan && (nan_cnt_q != '1)) nan_cnt_d = nan_cnt_q + 1'b1;

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = canon;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         mem_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         res_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_hi_q    <= 1'b0;
         nan_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_hi_q    <= out_hi_d;
         nan_cnt_q   <= nan_cnt_d;
      end
   end

endmodule

// File: tb/tb_tiny_nn_result_tx.sv
// Directed and randomized bench for tiny_nn_result_tx against a queue-based
// model of results waiting and bytes in flight.
module tb_tiny_nn_result_tx;

   localparam int DEPTH = 4;
   localparam int CW    = 8;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          res_valid_i = 1'b0;
   logic          res_ready_o;
   logic [15:0]   res_i = '0;
   logic          flush_i = 1'b0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b0;
   logic [7:0]    out_data_o;
   logic          out_hi_o;
   logic          empty_o;
   logic [CW-1:0] nan_count_o;

   int checks = 0;
   int errors = 0;

   tiny_nn_result_tx #(.FifoDepth(DEPTH), .CountWidth(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
      .res_i(res_i), .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_hi_o(out_hi_o), .empty_o(empty_o), .nan_count_o(nan_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] canon_f(input logic [15:0] v, output bit nan);
      int e, m;
      e   = int'(v[14:7]);
      m   = int'(v[6:0]);
      nan = (e == 0 && (m != 0 || v[15])) || (e == 255 && m != 0);
      return nan ? 16'hFFFF : v;
   endfunction

   // Reference model: results not yet started, and bytes of the result in flight.
   logic [15:0] waiting[$];
   logic [8:0]  inflight[$];
   int          nan_m = 0;

   always @(negedge clk) begin
      logic [15:0] r;
      bit          n;
      if (rst_i) begin
         chk("ready_in_reset", res_ready_o, 0);
         waiting.delete();
         inflight.delete();
         nan_m = 0;
      end else begin
         chk("out_valid", out_valid_o, inflight.size() != 0);
         if (inflight.size() != 0) chk("out_byte", {out_hi_o, out_data_o}, inflight[0]);
         chk("empty", empty_o, waiting.size() == 0 && inflight.size() == 0);
         chk("nan_count", nan_count_o, nan_m);
         chk("res_ready", res_ready_o, waiting.size() < DEPTH && !flush_i);
         if (out_valid_o && out_ready_i && inflight.size() != 0) void'(inflight.pop_front());
         if (inflight.size() == 0 && waiting.size() != 0 && !flush_i) begin
            r = waiting.pop_front();
            inflight.push_back({1'b1, r[15:8]});
            inflight.push_back({1'b0, r[7:0]});
         end
         if (flush_i) waiting.delete();
         if (res_valid_i && res_ready_o) begin
            r = canon_f(res_i, n);
            if (n && nan_m < (1 << CW) - 1) nan_m++;
            waiting.push_back(r);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] v);
      bit done = 0;
      res_valid_i = 1'b1;
      res_i       = v;
      for (int i = 0; i < 60 && !done; i++) begin
         if (res_ready_o) done = 1;
         tick();
      end
      res_valid_i = 1'b0;
      chk("push_timeout", done, 1);
   endtask

   initial begin
      logic [15:0] specials[8];
      logic [15:0] bp[6];
      logic [15:0] nanlist[5];
      bit          seen;
      specials = '{16'h8000, 16'h0001, 16'h7F81, 16'h7F80, 16'h0000, 16'hFF80, 16'hFFC0, 16'h3F80};
      bp       = '{16'hC000, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0};
      nanlist  = '{16'h8000, 16'h0001, 16'h7F81, 16'h7F80, 16'h0000};

      tick(2);
      chk("rst_valid", out_valid_o, 0);
      chk("rst_data", out_data_o, 0);
      chk("rst_hi", out_hi_o, 0);
      chk("rst_nan", nan_count_o, 0);
      chk("rst_empty", empty_o, 1);
      chk("rst_ready", res_ready_o, 0);
      rst_i = 1'b0;
      #1 chk("ready_after_rst", res_ready_o, 1);

      // Single result, latency and byte order
      out_ready_i = 1'b1;
      res_valid_i = 1'b1; res_i = 16'h3F80;
      tick();
      res_valid_i = 1'b0;
      chk("lat_valid_early", out_valid_o, 0);
      tick();
      chk("lat_valid", out_valid_o, 1);
      chk("lat_hi_byte", {out_hi_o, out_data_o}, 9'h13F);
      tick();
      chk("lat_lo_byte", {out_hi_o, out_data_o}, 9'h080);
      tick();
      chk("lat_idle", out_valid_o, 0);
      chk("lat_empty", empty_o, 1);

      // Canonicalisation
      foreach (nanlist[i]) push(nanlist[i]);
      tick(14);
      chk("nan3", nan_count_o, 3);

      // Backpressure fills FIFO plus output register
      out_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) push(bp[i]);
      tick(2);
      res_valid_i = 1'b1; res_i = bp[5];
      #1;
      chk("bp_full", res_ready_o, 0);
      chk("bp_hold", {out_valid_o, out_hi_o, out_data_o}, 10'h3C0);
      tick(3);
      chk("bp_still_hold", {out_hi_o, out_data_o}, 9'h1C0);
      out_ready_i = 1'b1;
      push(bp[5]);
      tick(16);
      chk("bp_drained", empty_o, 1);

      // Streaming without bubbles
      fork
         for (int i = 0; i < 8; i++) push(16'h4100 + 16'(i));
         begin
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
               if (out_valid_o) seen = 1; else tick();
            end
            chk("stream_start", seen, 1);
            for (int i = 0; i < 16; i++) begin
               chk("stream_valid", out_valid_o, 1);
               chk("stream_hi", out_hi_o, (i % 2) == 0);
               tick();
            end
            chk("stream_end", out_valid_o, 0);
         end
      join

      // Flush during SEND_HI with two queued
      out_ready_i = 1'b0;
      push(16'h4000); push(16'h4040); push(16'h4080);
      flush_i = 1'b1;
      #1 chk("flush_ready", res_ready_o, 0);
      tick();
      flush_i = 1'b0;
      out_ready_i = 1'b1;
      tick(6);
      chk("flush_empty", empty_o, 1);
      chk("flush_valid", out_valid_o, 0);

      // Reset during SEND_LO with three queued
      out_ready_i = 1'b0;
      push(16'h0001); push(16'h4000); push(16'h4040); push(16'h4080);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      chk("pre_rst_lo", {out_valid_o, out_hi_o}, 2'b10);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid_o, 0);
      chk("mid_rst_empty", empty_o, 1);
      chk("mid_rst_nan", nan_count_o, 0);
      chk("mid_rst_ready", res_ready_o, 1);
      out_ready_i = 1'b1;
      tick(6);
      chk("no_stale", out_valid_o, 0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         res_valid_i = 1'($urandom % 2);
         res_i       = ($urandom_range(0, 3) == 0) ? 16'($urandom) : specials[$urandom_range(0, 7)];
         out_ready_i = ($urandom % 4) != 0;
         flush_i     = ($urandom % 50) == 0;
         rst_i       = ($urandom % 1500) == 0;
         tick();
      end
      res_valid_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0; out_ready_i = 1'b1;
      tick(20);
      chk("final_empty", empty_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
